// File: rtl/out_mux_pkg.sv
// Shared definitions for the output channel selector.
//   state_t        : selector FSM states
//   DISP_BLANK     : all-ones pattern for the active-low digit/segment lines
//   NONE_FLAG      : MSB value of a candidate word meaning "no channel"
//   calc_ch_w      : channel index width, at least one bit
//   calc_cnt_w     : width of the shared settle/blank counter
package out_mux_pkg;

  typedef enum logic [1:0] {
    OFF,
    SETTLE,
    BLANK,
    ACTIVE
  } state_t;

  // Active-low display lines are dark when driven high; slice to the width needed.
  localparam logic [63:0] DISP_BLANK = '1;

  localparam logic NONE_FLAG = 1'b1;

  function automatic int unsigned calc_ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sel_settle_filter.sv
// Candidate register and shared counter for the output selector.
//   target     : requested channel word (MSB set = none)
//   load       : restart settling on the current target
//   settle_en  : debounce mode; a target change restarts the count
//   blank_en   : count out the blanking interval
//   cand       : candidate under consideration; the accepted value when accept=1
//   accept     : one-cycle pulse, candidate stable for SETTLE_CYCLES samples
//   blank_done : last cycle of the blanking interval
module sel_settle_filter
  import out_mux_pkg::*;
#(
  parameter int unsigned TGT_W         = 2,
  parameter int unsigned CNT_W         = 5,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned BLANK_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TGT_W-1:0] target,
  input  logic             load,
  input  logic             settle_en,
  input  logic             blank_en,
  output logic [TGT_W-1:0] cand,
  output logic             accept,
  output logic             blank_done
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             stable;

  assign stable     = (target == cand);
  assign accept     = settle_en && stable && (cnt == SETTLE_LAST);
  assign blank_done = blank_en && (cnt == BLANK_LAST);

  // The counter is reused: zeroed on accept so blanking starts from 0, and it
  // stops at its last value in either mode so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand <= {NONE_FLAG, {(TGT_W-1){1'b0}}};
      cnt  <= '0;
    end else if (load || (settle_en && !stable)) begin
      cand <= target;
      cnt  <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (settle_en || (blank_en && !blank_done)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/output_channel_mux.sv
// Registered, debounced selector driving the shared display, LED bank and
// auxiliary LEDs from one of NUM_CH producer channels, with a blanking gap on
// every switch between two live channels.
//   clk, rst (async, active-low), enable, sel : control
//   ch_seg_en/ch_seg_out/ch_led/ch_aux        : flattened per-channel inputs
//   ch_active                                 : one-hot granted channel or zero
//   seg_en/seg_out (active-low), led, aux     : display outputs
//   switching                                 : high while in SETTLE or BLANK
module output_channel_mux
  import out_mux_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SEG_EN_W      = 8,
  parameter int unsigned SEG_OUT_W     = 8,
  parameter int unsigned LED_W         = 14,
  parameter int unsigned AUX_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned BLANK_CYCLES  = 4,
  localparam int unsigned CH_W         = calc_ch_w(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [CH_W-1:0]             sel,
  input  logic [NUM_CH*SEG_EN_W-1:0]  ch_seg_en,
  input  logic [NUM_CH*SEG_OUT_W-1:0] ch_seg_out,
  input  logic [NUM_CH*LED_W-1:0]     ch_led,
  input  logic [NUM_CH*AUX_W-1:0]     ch_aux,
  output logic [NUM_CH-1:0]           ch_active,
  output logic [SEG_EN_W-1:0]         seg_en,
  output logic [SEG_OUT_W-1:0]        seg_out,
  output logic [LED_W-1:0]            led,
  output logic [AUX_W-1:0]            aux,
  output logic                        switching
);

  localparam int unsigned TGT_W = CH_W + 1;
  localparam int unsigned CNT_W = calc_cnt_w(SETTLE_CYCLES, BLANK_CYCLES);
  localparam logic [TGT_W-1:0] TGT_NONE = {NONE_FLAG, {CH_W{1'b0}}};

  state_t           state, state_d;
  logic [CH_W-1:0]  cur;
  logic             cur_valid;
  logic             sel_in_range;
  logic [TGT_W-1:0] target;
  logic [TGT_W-1:0] cand;
  logic             load, settle_en, blank_en, accept, blank_done;
  logic             cur_load, cur_clr;
  logic             live;

  logic [SEG_EN_W-1:0]  mux_seg_en;
  logic [SEG_OUT_W-1:0] mux_seg_out;
  logic [LED_W-1:0]     mux_led;
  logic [AUX_W-1:0]     mux_aux;
  logic [NUM_CH-1:0]    cur_onehot;

  if ((1 << CH_W) > NUM_CH) begin : g_range_chk
    assign sel_in_range = (32'(sel) < NUM_CH);
  end else begin : g_range_full
    assign sel_in_range = 1'b1;
  end

  assign target = (enable && sel_in_range) ? {1'b0, sel} : TGT_NONE;

  sel_settle_filter #(
    .TGT_W        (TGT_W),
    .CNT_W        (CNT_W),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .target    (target),
    .load      (load),
    .settle_en (settle_en),
    .blank_en  (blank_en),
    .cand      (cand),
    .accept    (accept),
    .blank_done(blank_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= OFF;
      cur       <= '0;
      cur_valid <= 1'b0;
    end else begin
      state <= state_d;
      if (cur_load) begin
        cur       <= cand[CH_W-1:0];
        cur_valid <= 1'b1;
      end else if (cur_clr) begin
        cur_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    settle_en = 1'b0;
    blank_en  = 1'b0;
    cur_load  = 1'b0;
    cur_clr   = 1'b0;
    case (state)
      OFF: begin
        if (target != TGT_NONE) begin
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        settle_en = 1'b1;
        if (accept) begin
          if (cand[CH_W]) begin
            cur_clr = 1'b1;
            state_d = OFF;
          end else if (cur_valid && (cand[CH_W-1:0] == cur)) begin
            state_d = ACTIVE;
          end else begin
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        blank_en = 1'b1;
        if (blank_done) begin
          cur_load = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (target != {1'b0, cur}) begin
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Compare-and-select per channel keeps every index in range for any NUM_CH.
  always_comb begin
    mux_seg_en  = ch_seg_en[SEG_EN_W-1:0];
    mux_seg_out = ch_seg_out[SEG_OUT_W-1:0];
    mux_led     = ch_led[LED_W-1:0];
    mux_aux     = ch_aux[AUX_W-1:0];
    cur_onehot  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur == CH_W'(i)) begin
        mux_seg_en    = ch_seg_en[i*SEG_EN_W +: SEG_EN_W];
        mux_seg_out   = ch_seg_out[i*SEG_OUT_W +: SEG_OUT_W];
        mux_led       = ch_led[i*LED_W +: LED_W];
        mux_aux       = ch_aux[i*AUX_W +: AUX_W];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // SETTLE keeps showing the granted channel so a short glitch is invisible.
  assign live = (state == ACTIVE) || ((state == SETTLE) && cur_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_en    <= DISP_BLANK[SEG_EN_W-1:0];
      seg_out   <= DISP_BLANK[SEG_OUT_W-1:0];
      led       <= '0;
      aux       <= '0;
      ch_active <= '0;
      switching <= 1'b0;
    end else begin
      if (live) begin
        seg_en    <= mux_seg_en;
        seg_out   <= mux_seg_out;
        led       <= mux_led;
        aux       <= mux_aux;
        ch_active <= cur_onehot;
      end else begin
        seg_en    <= DISP_BLANK[SEG_EN_W-1:0];
        seg_out   <= DISP_BLANK[SEG_OUT_W-1:0];
        led       <= '0;
        aux       <= '0;
        ch_active <= '0;
      end
      switching <= (state_d == SETTLE) || (state_d == BLANK);
    end
  end

endmodule

// File: tb/tb_output_channel_mux.sv
module tb_output_channel_mux;

  localparam int NUM_CH = 3;
  localparam int SETTLE = 16;
  localparam int BLANKN = 4;
  localparam logic [31:0] DISP_OFF = {8'hFF, 8'hFF, 14'h0, 2'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  sel;
  logic [23:0] ch_seg_en;
  logic [23:0] ch_seg_out;
  logic [41:0] ch_led;
  logic [5:0]  ch_aux;
  logic [2:0]  ch_active;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic [13:0] led;
  logic [1:0]  aux;
  logic        switching;

  logic [7:0]  d_seg_en  [NUM_CH];
  logic [7:0]  d_seg_out [NUM_CH];
  logic [13:0] d_led     [NUM_CH];
  logic [1:0]  d_aux     [NUM_CH];

  assign ch_seg_en  = {d_seg_en[2], d_seg_en[1], d_seg_en[0]};
  assign ch_seg_out = {d_seg_out[2], d_seg_out[1], d_seg_out[0]};
  assign ch_led     = {d_led[2], d_led[1], d_led[0]};
  assign ch_aux     = {d_aux[2], d_aux[1], d_aux[0]};

  output_channel_mux #(
    .NUM_CH       (NUM_CH),
    .SEG_EN_W     (8),
    .SEG_OUT_W    (8),
    .LED_W        (14),
    .AUX_W        (2),
    .SETTLE_CYCLES(SETTLE),
    .BLANK_CYCLES (BLANKN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sel       (sel),
    .ch_seg_en (ch_seg_en),
    .ch_seg_out(ch_seg_out),
    .ch_led    (ch_led),
    .ch_aux    (ch_aux),
    .ch_active (ch_active),
    .seg_en    (seg_en),
    .seg_out   (seg_out),
    .led       (led),
    .aux       (aux),
    .switching (switching)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: channel -1 means "no channel".
  int          m_cur, m_cand, m_age, m_blank_left;
  bit          m_settling;
  logic [31:0] e_disp;
  logic [2:0]  e_act;
  logic        e_sw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] disp_now();
    return {seg_en, seg_out, led, aux};
  endfunction

  task automatic model_reset();
    m_cur = -1; m_cand = -1; m_age = 0; m_blank_left = 0; m_settling = 1'b0;
    e_disp = DISP_OFF; e_act = '0; e_sw = 1'b0;
  endtask

  // One clock edge: outputs show what was presented entering the edge, then
  // the selection rules advance.
  task automatic model_edge();
    int t;
    t = (enable && int'(sel) < NUM_CH) ? int'(sel) : -1;
    if (m_blank_left == 0 && m_cur >= 0) begin
      e_disp = {d_seg_en[m_cur], d_seg_out[m_cur], d_led[m_cur], d_aux[m_cur]};
      e_act  = 3'(1 << m_cur);
    end else begin
      e_disp = DISP_OFF;
      e_act  = '0;
    end
    if (m_blank_left > 0) begin
      m_blank_left--;
      if (m_blank_left == 0) m_cur = m_cand;
    end else if (m_settling) begin
      if (t != m_cand) begin
        m_cand = t;
        m_age  = 0;
      end else begin
        m_age++;
        if (m_age == SETTLE) begin
          m_settling = 1'b0;
          if (m_cand < 0) m_cur = -1;
          else if (m_cand != m_cur) m_blank_left = BLANKN;
        end
      end
    end else if (t != m_cur) begin
      m_settling = 1'b1;
      m_cand     = t;
      m_age      = 0;
    end
    e_sw = m_settling || (m_blank_left > 0);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NUM_CH; i++) begin
      d_seg_en[i]  = 8'($urandom);
      d_seg_out[i] = 8'($urandom);
      d_led[i]     = 14'($urandom);
      d_aux[i]     = 2'($urandom);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("disp", disp_now(), e_disp);
    check("ch_active", 32'(ch_active), 32'(e_act));
    check("switching", 32'(switching), 32'(e_sw));
    randomize_data();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; sel = '0;
    randomize_data();
    model_reset();
    #12;
    check("reset_disp", disp_now(), DISP_OFF);
    check("reset_act", 32'(ch_active), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Power-up on channel 0: 16 settle, 4 blank, then ch0 data.
    enable = 1'b1; sel = 2'd0;
    run(SETTLE + BLANKN + 2);
    check("s1_act", 32'(ch_active), 32'b001);

    // Short glitch to channel 1 must not disturb the display.
    sel = 2'd1; run(5);
    sel = 2'd0; run(SETTLE + 4);
    check("glitch_act", 32'(ch_active), 32'b001);

    // Committed switch to channel 1.
    sel = 2'd1; run(SETTLE + BLANKN + 3);
    check("s3_act", 32'(ch_active), 32'b010);

    // Out-of-range selection turns the display off.
    sel = 2'd3; run(SETTLE + 4);
    check("oor_act", 32'(ch_active), 32'd0);
    check("oor_disp", disp_now(), DISP_OFF);

    // Selection toggles during blanking; blanking completes on old candidate.
    sel = 2'd2; run(SETTLE + 1);
    check("in_blank_sw", 32'(switching), 32'd1);
    sel = 2'd0; run(2);
    sel = 2'd1; run(1);
    sel = 2'd0; run(2 * SETTLE + 2 * BLANKN + 4);
    check("s5_act", 32'(ch_active), 32'b001);

    // Asynchronous reset in the middle of settling.
    sel = 2'd2; run(5);
    #2 rst = 1'b0;
    #1;
    check("async_disp", disp_now(), DISP_OFF);
    check("async_act", 32'(ch_active), 32'd0);
    check("async_sw", 32'(switching), 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    sel = 2'd0;
    run(SETTLE + BLANKN + 2);
    check("post_rst_act", 32'(ch_active), 32'b001);

    // Randomised selection runs of varying length.
    for (int r = 0; r < 24; r++) begin
      enable = ($urandom_range(0, 7) != 0);
      sel    = 2'($urandom_range(0, 3));
      run($urandom_range(1, 26));
    end

    // Disable is debounced like any other change and ends in OFF.
    enable = 1'b0;
    run(2 * SETTLE + BLANKN + 4);
    check("disable_act", 32'(ch_active), 32'd0);
    check("disable_disp", disp_now(), DISP_OFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_channel_mux.md
# output_channel_mux

Parametrised, registered successor to the top-level decoder/encoder output selector. It drives the shared 7-segment display, LED bank and auxiliary LEDs from one of NUM_CH producer channels. Channel selection is debounced, and every switch between two live channels passes through a fixed blanking interval, so the display never shows a torn frame. The block sits at board top level between the channel controllers and the pins.

## Interface
- NUM_CH, 2: producer channel count (≥2)
- SEG_EN_W, 8: digit-enable width (active-low)
- SEG_OUT_W, 8: segment width (active-low)
- LED_W, 14: LED bank width
- AUX_W, 2: auxiliary LED width
- SETTLE_CYCLES, 16: cycles a selection must be stable before acceptance (≥1)
- BLANK_CYCLES, 4: blank cycles inserted on a live-to-live switch (≥1)
- CH_W (local) = max(1, $clog2(NUM_CH))

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  master on switch
- sel  in  CH_W  requested channel index
- ch_seg_en  in  NUM_CH*SEG_EN_W  per-channel digit enables; channel i at [i*SEG_EN_W +: SEG_EN_W]
- ch_seg_out  in  NUM_CH*SEG_OUT_W  per-channel segments
- ch_led  in  NUM_CH*LED_W  per-channel LEDs
- ch_aux  in  NUM_CH*AUX_W  per-channel auxiliary LEDs
- ch_active  out  NUM_CH  one-hot granted channel, or all zero; drives the mode lights and the channel controllers' enables
- seg_en  out  SEG_EN_W  display digit enables
- seg_out  out  SEG_OUT_W  display segments
- led  out  LED_W  LED bank
- aux  out  AUX_W  auxiliary LEDs
- switching  out  1  high in SETTLE and BLANK

## Operation
- Target = sel when enable=1 and sel<NUM_CH; otherwise NONE.
- Blank value: seg_en and seg_out all ones; led and aux zero; ch_active zero.
- Registers: state, cand (target being settled), cur plus cur_valid (granted channel), cnt.
- States:
  - OFF: outputs blank. If target≠NONE, set cand=target, cnt=0, go to SETTLE.
  - SETTLE: outputs hold the previous display. That is ch[cur] if cur_valid, else blank.
    - If target≠cand: cand=target, cnt=0, stay in SETTLE.
    - Else if cnt==SETTLE_CYCLES-1, accept cand:
      - cand==NONE: go to OFF and clear cur_valid.
      - cur_valid and cand==cur: go back to ACTIVE with no blank.
      - Otherwise: go to BLANK with cnt=0.
    - Else cnt++.
  - BLANK: outputs blank and ch_active=0. When cnt==BLANK_CYCLES-1, set cur=cand and cur_valid=1, then go to ACTIVE. Else cnt++. A target change during BLANK does not abort it; after BLANK the block enters ACTIVE and re-settles from there.
  - ACTIVE: outputs follow ch[cur] and ch_active[cur]=1. If target≠cur, set cand=target, cnt=0, go to SETTLE.
- enable falling to 0 is debounced like any other change. It reaches OFF after SETTLE_CYCLES.

## Timing
- All outputs are registered. In ACTIVE, outputs at edge t+1 reflect ch_* at edge t, a 1-cycle latency.
- On reset assertion, asynchronously: state=OFF, cur_valid=0, cnt=0, cand=NONE, outputs blank.
- From OFF, a stable target T first sampled at edge k gives:
  - SETTLE during edges k+1 … k+SETTLE_CYCLES
  - BLANK for BLANK_CYCLES cycles
  - first ACTIVE output after k+1+SETTLE_CYCLES+BLANK_CYCLES
- ch_active is never high during BLANK. No output ever mixes two channels within a cycle.
- A glitch shorter than SETTLE_CYCLES leaves the display and ch_active unchanged.
- cnt width is $clog2(max(SETTLE_CYCLES, BLANK_CYCLES)+1). cnt never wraps.
- Reset asserted mid-operation takes effect immediately. After release, the block restarts from OFF.

## Structure
- Package out_mux_pkg holds:
  - the state enum (OFF, SETTLE, BLANK, ACTIVE)
  - the all-ones blank constant for active-low display signals
  - the NONE encoding (cand is CH_W+1 bits; MSB marks NONE)
- Sub-module sel_settle_filter holds cand, cnt and the stable-for-N comparison, and emits an accept pulse with the accepted value.

## Test plan
- Reset, then enable=1, sel=0, stable: 16 SETTLE cycles, 4 BLANK cycles, then ch_active=01 and seg_out equals ch0's value one cycle later.
- In ACTIVE ch0, sel goes 0→1 for 5 cycles then back to 0: ch_active stays 01 and the display is never blanked.
- In ACTIVE ch0, sel=1 held: exactly 16 cycles of ch0, 4 cycles all-ones/zero, then ch_active=10 and ch1 data.
- Out-of-range sel (NUM_CH=3, sel=3) held 16 cycles: block goes to OFF with all outputs blank.
- sel toggles during BLANK: BLANK completes and ACTIVE is entered on the old cand. SETTLE then starts again and the final channel matches the stable sel.
- rst pulsed low mid-SETTLE: outputs blank in the same cycle, without waiting for a clock edge. After release the block behaves exactly as in the first scenario.
